// File: rtl/shift_reg_univ.sv
// Universal word shift register with a saturating fill counter.
// DEPTH stages of WIDTH bits. Per-cycle mode: hold, shift up, shift down or
// parallel load. Also provides a synchronous clear and an asynchronous reset.

// Two-input word mux, WIDTH bits: o_y = i_sel ? i_b : i_a.
module mux2 #(
    parameter int WIDTH = 1
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = i_sel ? i_b : i_a;
endmodule

module shift_reg_univ #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int FW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       din_lo,
    input  logic [WIDTH-1:0]       din_hi,
    input  logic [WIDTH*DEPTH-1:0] pin,
    output logic [WIDTH*DEPTH-1:0] pout,
    output logic [WIDTH-1:0]       sout_lo,
    output logic [WIDTH-1:0]       sout_hi,
    output logic [FW-1:0]          fill,
    output logic                   full
);

    logic [WIDTH-1:0] r_stage [DEPTH];
    logic [FW-1:0]    r_fill;

    logic [WIDTH-1:0] w_next [DEPTH];
    logic [FW-1:0]    w_fill_next;

    // Per-stage next-value selection. mode[0] picks within each pair
    // {hold, up} / {down, load}, and mode[1] then picks the pair.
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [WIDTH-1:0] w_up_src;
        logic [WIDTH-1:0] w_dn_src;
        logic [WIDTH-1:0] w_pair_lo;
        logic [WIDTH-1:0] w_pair_hi;

        if (g == 0) begin : g_up_edge
            assign w_up_src = din_lo;
        end else begin : g_up_mid
            assign w_up_src = r_stage[g-1];
        end

        if (g == DEPTH - 1) begin : g_dn_edge
            assign w_dn_src = din_hi;
        end else begin : g_dn_mid
            assign w_dn_src = r_stage[g+1];
        end

        mux2 #(.WIDTH(WIDTH)) u_mux_lo (
            .i_sel (mode[0]),
            .i_a   (r_stage[g]),
            .i_b   (w_up_src),
            .o_y   (w_pair_lo)
        );

        mux2 #(.WIDTH(WIDTH)) u_mux_hi (
            .i_sel (mode[0]),
            .i_a   (w_dn_src),
            .i_b   (pin[g*WIDTH +: WIDTH]),
            .o_y   (w_pair_hi)
        );

        mux2 #(.WIDTH(WIDTH)) u_mux_sel (
            .i_sel (mode[1]),
            .i_a   (w_pair_lo),
            .i_b   (w_pair_hi),
            .o_y   (w_next[g])
        );

        assign pout[g*WIDTH +: WIDTH] = r_stage[g];
    end

    // Fill counter next value: shifts saturate at DEPTH, and a load sets it to DEPTH.
    always_comb begin
        w_fill_next = r_fill;
        case (mode)
            2'b01, 2'b10: begin
                if (r_fill != FW'(DEPTH)) begin
                    w_fill_next = r_fill + FW'(1);
                end
            end
            2'b11:   w_fill_next = FW'(DEPTH);
            default: w_fill_next = r_fill;
        endcase
    end

    // Stage and fill registers. The priority order is rst, then clr, then mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
            r_fill <= '0;
        end else if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
            r_fill <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= w_next[i];
            end
            r_fill <= w_fill_next;
        end
    end

    assign sout_lo = r_stage[0];
    assign sout_hi = r_stage[DEPTH-1];
    assign fill    = r_fill;
    assign full    = (r_fill == FW'(DEPTH));

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ. It drives two instances: 8x4 and 1x1.
// A queue-based reference model is checked every cycle, and literal
// expectations pin the model itself.
module tb_shift_reg_univ;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [1:0]  mode;
    logic [7:0]  din_lo;
    logic [7:0]  din_hi;
    logic [31:0] pin;
    logic [31:0] pout;
    logic [7:0]  sout_lo;
    logic [7:0]  sout_hi;
    logic [2:0]  fill;
    logic        full;

    logic        clr1;
    logic [1:0]  mode1;
    logic        din_lo1;
    logic        din_hi1;
    logic        pin1;
    logic        pout1;
    logic        sout_lo1;
    logic        sout_hi1;
    logic        fill1;
    logic        full1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    shift_reg_univ #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .clr(clr), .mode(mode),
        .din_lo(din_lo), .din_hi(din_hi), .pin(pin),
        .pout(pout), .sout_lo(sout_lo), .sout_hi(sout_hi),
        .fill(fill), .full(full)
    );

    shift_reg_univ #(.WIDTH(1), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr1), .mode(mode1),
        .din_lo(din_lo1), .din_hi(din_hi1), .pin(pin1),
        .pout(pout1), .sout_lo(sout_lo1), .sout_hi(sout_hi1),
        .fill(fill1), .full(full1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. Queue element 0 is stage 0.
    // Shifting up pushes in at the front and drops the back.
    logic [7:0] mq[$] = '{8'h00, 8'h00, 8'h00, 8'h00};
    int         mfill = 0;
    logic       m1 = 1'b0;
    int         m1fill = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq = '{8'h00, 8'h00, 8'h00, 8'h00};
            mfill = 0;
            m1 = 1'b0;
            m1fill = 0;
        end else begin
            if (clr) begin
                mq = '{8'h00, 8'h00, 8'h00, 8'h00};
                mfill = 0;
            end else if (mode == 2'b01) begin
                mq.push_front(din_lo);
                void'(mq.pop_back());
                mfill = (mfill < 4) ? mfill + 1 : 4;
            end else if (mode == 2'b10) begin
                mq.push_back(din_hi);
                void'(mq.pop_front());
                mfill = (mfill < 4) ? mfill + 1 : 4;
            end else if (mode == 2'b11) begin
                mq = '{pin[7:0], pin[15:8], pin[23:16], pin[31:24]};
                mfill = 4;
            end
            if (clr1) begin
                m1 = 1'b0;
                m1fill = 0;
            end else if (mode1 == 2'b01) begin
                m1 = din_lo1;
                m1fill = 1;
            end else if (mode1 == 2'b10) begin
                m1 = din_hi1;
                m1fill = 1;
            end else if (mode1 == 2'b11) begin
                m1 = pin1;
                m1fill = 1;
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_pout", pout, {mq[3], mq[2], mq[1], mq[0]});
            chk("model_sout_lo", {24'h0, sout_lo}, {24'h0, mq[0]});
            chk("model_sout_hi", {24'h0, sout_hi}, {24'h0, mq[3]});
            chk("model_fill", {29'h0, fill}, mfill);
            chk("model_full", {31'h0, full}, {31'h0, mfill == 4});
            chk("model1_pout", {31'h0, pout1}, {31'h0, m1});
            chk("model1_souts", {30'h0, sout_hi1, sout_lo1}, {30'h0, m1, m1});
            chk("model1_fill", {31'h0, fill1}, m1fill);
            chk("model1_full", {31'h0, full1}, {31'h0, m1fill == 1});
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; mode = 2'b00;
        din_lo = '0; din_hi = '0; pin = '0;
        clr1 = 1'b0; mode1 = 2'b00; din_lo1 = 1'b0; din_hi1 = 1'b0; pin1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_pout", pout, 32'h0);
        chk("reset_fill", {29'h0, fill}, 32'd0);
        chk("reset_full", {31'h0, full}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Shift up four words. Alongside it, DEPTH=1 takes din_lo.
        mode = 2'b01; din_lo = 8'h11;
        mode1 = 2'b01; din_lo1 = 1'b1;
        cyc();
        chk("up1_fill", {29'h0, fill}, 32'd1);
        chk("d1_up_pout", {31'h0, pout1}, 32'd1);
        chk("d1_up_full", {31'h0, full1}, 32'd1);
        mode1 = 2'b10; din_hi1 = 1'b0;
        din_lo = 8'h22;
        cyc();
        chk("up2_fill", {29'h0, fill}, 32'd2);
        chk("d1_dn_pout", {31'h0, pout1}, 32'd0);
        chk("d1_dn_fill", {31'h0, fill1}, 32'd1);
        mode1 = 2'b00;
        din_lo = 8'h33;
        cyc();
        chk("up3_fill", {29'h0, fill}, 32'd3);
        chk("up3_full", {31'h0, full}, 32'd0);
        din_lo = 8'h44;
        cyc();
        chk("up4_pout", pout, 32'h11223344);
        chk("up4_sout_lo", {24'h0, sout_lo}, 32'h44);
        chk("up4_sout_hi", {24'h0, sout_hi}, 32'h11);
        chk("up4_fill", {29'h0, fill}, 32'd4);
        chk("up4_full", {31'h0, full}, 32'd1);

        // Shift down one word.
        mode = 2'b10; din_hi = 8'hAA;
        cyc();
        chk("dn_pout", pout, 32'hAA112233);
        chk("dn_sout_lo", {24'h0, sout_lo}, 32'h33);

        // A fifth shift must keep the fill count saturated.
        mode = 2'b01; din_lo = 8'h55;
        cyc();
        chk("sat_pout", pout, 32'h11223355);
        chk("sat_fill", {29'h0, fill}, 32'd4);

        // clr takes priority over load.
        clr = 1'b1; mode = 2'b11; pin = 32'hFFFFFFFF;
        cyc();
        chk("clr_pout", pout, 32'h0);
        chk("clr_fill", {29'h0, fill}, 32'd0);
        chk("clr_full", {31'h0, full}, 32'd0);
        clr = 1'b0;

        // Load, then hold for three cycles.
        pin = 32'hDEADBEEF;
        cyc();
        chk("load_pout", pout, 32'hDEADBEEF);
        chk("load_fill", {29'h0, fill}, 32'd4);
        mode = 2'b00; pin = 32'h12345678;
        repeat (3) cyc();
        chk("hold_pout", pout, 32'hDEADBEEF);
        chk("hold_fill", {29'h0, fill}, 32'd4);

        // Shift down from empty: fill counts up from 0.
        clr = 1'b1;
        cyc();
        clr = 1'b0; mode = 2'b10; din_hi = 8'h5A;
        cyc();
        chk("dn0_pout", pout, 32'h5A000000);
        chk("dn0_fill", {29'h0, fill}, 32'd1);

        // An X on mode is ignored while clr is high.
        mode = 2'bxx;
        clr = 1'b1;
        cyc();
        chk("clrx_pout", pout, 32'h0);
        clr = 1'b0; mode = 2'b11; pin = 32'h0BADF00D;
        cyc();

        // Assert rst between edges: the state must clear before the next edge.
        mode = 2'b01; din_lo = 8'h77;
        #2 rst = 1'b1;
        #1;
        chk("arst_pout", pout, 32'h0);
        chk("arst_fill", {29'h0, fill}, 32'd0);
        chk("arst_full", {31'h0, full}, 32'd0);
        @(negedge clk);
        chk("arst_hold_pout", pout, 32'h0);
        rst = 1'b0;

        // A mixed directed sequence, checked by the model.
        for (int i = 0; i < 24; i++) begin
            mode = 2'(i % 4);
            if (i % 7 == 0) mode = 2'b01;
            din_lo = 8'(8'h10 + i);
            din_hi = 8'(8'hC0 + i);
            pin = 32'hA5000000 | 32'(i * 32'h01010101);
            clr = (i == 13);
            mode1 = 2'((i + 1) % 4);
            din_lo1 = 1'(i);
            din_hi1 = ~1'(i);
            pin1 = 1'(i >> 1);
            clr1 = (i == 9);
            cyc();
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
